// File: rtl/ssd_capture_if.sv
// ssd_capture_if: board-side seven-segment bus plus the reconstructed view.
//   seg         : segment lines, active-low, bit 6 = a ... bit 0 = g
//   an          : digit anodes, active-low, an[i] low selects digit i
//   digits      : captured code per digit, digit i at [4*i+3:4*i] (4'hF = blank)
//   digit_valid : digit i captured at least once since reset
//   frame_valid : one-cycle pulse when every digit has been captured again
//   err         : one-cycle pulse on an illegal capture
//   err_digit   : digit index of the last error, 7 when several anodes were low
// master = the display / stimulus side, slave = the capture block.
interface ssd_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_valid;
  logic                    err;
  logic [2:0]              err_digit;

  modport master (
    output seg, an,
    input  digits, digit_valid, frame_valid, err, err_digit
  );

  modport slave (
    input  seg, an,
    output digits, digit_valid, frame_valid, err, err_digit
  );
endinterface

// File: rtl/ssd_capture.sv
// ssd_capture: snoops a multiplexed active-low seven-segment bus and rebuilds
// the BCD value shown on each digit.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : ssd_capture_if.slave (seg/an in; digits, digit_valid, frame_valid,
//         err, err_digit out)
// Pipeline: 2-flop synchroniser -> settle filter -> anode classification and
// pattern decode -> per-digit storage with frame and error reporting.
module ssd_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst,
  ssd_capture_if.slave bus
);

  localparam int W = 7 + NUM_DIGITS;

  logic [W-1:0]            sync1, sync2, prev;
  logic [7:0]              stab_cnt;
  logic                    strobe;
  logic [6:0]              seg_c;
  logic [NUM_DIGITS-1:0]   an_low;
  logic                    multi;
  logic [2:0]              sel;
  logic [4:0]              dec;

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic [NUM_DIGITS-1:0]   seen_q;
  logic                    frame_q;
  logic                    err_q;
  logic [2:0]              err_digit_q;

  // Returns {legal, code}. Blank (all segments off) is a legal code 4'hF.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: return {1'b1, 4'd0};
      7'b1001111: return {1'b1, 4'd1};
      7'b0010010: return {1'b1, 4'd2};
      7'b0000110: return {1'b1, 4'd3};
      7'b1001100: return {1'b1, 4'd4};
      7'b0100100: return {1'b1, 4'd5};
      7'b0100000: return {1'b1, 4'd6};
      7'b0001111: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0000100: return {1'b1, 4'd9};
      7'b1111111: return {1'b1, 4'hF};
      default:    return {1'b0, 4'h0};
    endcase
  endfunction

  // Synchroniser resets to all-ones (dark display); prev holds the sync output
  // of the previous cycle so the settle filter can spot any change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '1;
      sync2    <= '1;
      prev     <= '1;
      stab_cnt <= '0;
    end else begin
      sync1 <= {bus.seg, bus.an};
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 != prev)
        stab_cnt <= '0;
      else if (stab_cnt < 8'(STABLE_CYCLES))
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  // Fires on the edge where the counter reaches STABLE_CYCLES, so it can only
  // fire once per settled value; saturation keeps it quiet afterwards.
  assign strobe = (sync2 == prev) && (stab_cnt == 8'(STABLE_CYCLES - 1));

  assign seg_c  = prev[W-1:NUM_DIGITS];
  assign an_low = ~prev[NUM_DIGITS-1:0];
  assign multi  = (an_low & (an_low - NUM_DIGITS'(1))) != '0;
  assign dec    = decode(seg_c);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (an_low[i]) sel = 3'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q    <= '1;
      valid_q     <= '0;
      seen_q      <= '0;
      frame_q     <= 1'b0;
      err_q       <= 1'b0;
      err_digit_q <= '0;
    end else begin
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      if (strobe && (an_low != '0)) begin
        if (multi) begin
          err_q       <= 1'b1;
          err_digit_q <= 3'd7;
        end else if (!dec[4]) begin
          err_q       <= 1'b1;
          err_digit_q <= sel;
        end else begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (an_low[i]) digits_q[4*i +: 4] <= dec[3:0];
          valid_q <= valid_q | an_low;
          // Frame completes on the write of the last missing digit.
          if ((seen_q | an_low) == '1) begin
            frame_q <= 1'b1;
            seen_q  <= '0;
          end else begin
            seen_q <= seen_q | an_low;
          end
        end
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.frame_valid = frame_q;
  assign bus.err         = err_q;
  assign bus.err_digit   = err_digit_q;

endmodule
